// File: rtl/moore_pattern_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// Contents: FSM state enum, B/C symbol codes, default BCCBC frame.
package moore_pattern_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic SYM_B = 1'b0;
   localparam logic SYM_C = 1'b1;

   localparam int DEF_W = 5;

   // BCCBC, sent MSB first
   localparam logic [DEF_W-1:0] PAT_DEF = {
      SYM_B, SYM_C, SYM_C, SYM_B, SYM_C
   };

endpackage

// File: rtl/moore_pattern_gen_shift.sv
// pattern_shift_reg: frame shadow, MSB-first shifter, bit index.
// Ports: load_i/frame_i capture, reload_i restart, shift_i step;
//        bit_o current, next_o following, head_o frame MSB,
//        first_o/last_o/nlast_o index position flags.
module pattern_shift_reg
   import moore_pattern_pkg::*;
#(
   parameter int PAT_W = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [PAT_W-1:0] frame_i,
   input  logic             reload_i,
   input  logic             shift_i,
   output logic             bit_o,
   output logic             next_o,
   output logic             head_o,
   output logic             first_o,
   output logic             last_o,
   output logic             nlast_o
);

   localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

   logic [PAT_W-1:0] frame_q;
   logic [PAT_W-1:0] sreg_q;
   logic [IDX_W-1:0] idx_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         frame_q <= '0;
         sreg_q  <= '0;
         idx_q   <= '0;
      end else if (load_i) begin
         frame_q <= frame_i;
         sreg_q  <= frame_i;
         idx_q   <= IDX_TOP;
      end else if (reload_i) begin
         sreg_q  <= frame_q;
         idx_q   <= IDX_TOP;
      end else if (shift_i) begin
         sreg_q  <= {sreg_q[PAT_W-2:0], SYM_B};
         idx_q   <= idx_q - 1'b1;
      end
   end

   assign bit_o   = sreg_q[PAT_W-1];
   assign next_o  = sreg_q[PAT_W-2];
   assign head_o  = frame_q[PAT_W-1];
   assign first_o = (idx_q == IDX_TOP);
   assign last_o  = (idx_q == '0);
   assign nlast_o = (idx_q == IDX_W'(1));

endmodule

// File: rtl/moore_pattern_gen.sv
// moore_pattern_gen: valid/ready serial frame transmitter with repeat
// and inter-frame gap. Inputs: clk_i, rst_i (async, active-low),
// start_i, use_def_i, pattern_i, rep_i, gap_i, ready_i.
// Outputs (all registered): valid_o, data_o, busy_o, done_o.
// Optional: define PATGEN_ERR_INJECT_EN to add inject_i, which flips
// bit 0 of the next frame to start.
module moore_pattern_gen
   import moore_pattern_pkg::*;
#(
   parameter int PAT_W = 5,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEF),
   parameter int CNT_W = 4,
   parameter int GAP_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             use_def_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [CNT_W-1:0] rep_i,
   input  logic [GAP_W-1:0] gap_i,
   input  logic             ready_i,
`ifdef PATGEN_ERR_INJECT_EN
   input  logic             inject_i,
`endif
   output logic             valid_o,
   output logic             data_o,
   output logic             busy_o,
   output logic             done_o
);

   state_t           state_q;
   logic [CNT_W-1:0] reps_q;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_cnt_q;

   logic             sr_bit;
   logic             sr_next;
   logic             sr_head;
   logic             sr_first;
   logic             sr_last;
   logic             sr_nlast;

   logic             xfer;
   logic             load;
   logic             reload;
   logic             shift;
   logic             more;
   logic             inj_cur_n;
   logic [PAT_W-1:0] frame_sel;

   assign xfer   = (state_q == SEND) & valid_o & ready_i;
   assign load   = (state_q == IDLE) & start_i;
   assign reload = xfer & sr_last;
   assign shift  = xfer & ~sr_last;
   assign more   = (reps_q > CNT_W'(1));

   assign frame_sel = use_def_i ? PAT_DEFAULT : pattern_i;

   pattern_shift_reg #(
      .PAT_W (PAT_W)
   ) u_sreg (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (load),
      .frame_i  (frame_sel),
      .reload_i (reload),
      .shift_i  (shift),
      .bit_o    (sr_bit),
      .next_o   (sr_next),
      .head_o   (sr_head),
      .first_o  (sr_first),
      .last_o   (sr_last),
      .nlast_o  (sr_nlast)
   );

`ifdef PATGEN_ERR_INJECT_EN
   // arm: request pending for the next frame start
   // cur: the frame now on the wire gets bit 0 flipped
   logic inj_arm_q;
   logic inj_cur_q;

   // cur must be seen the same cycle the MSB leaves,
   // in case the following bit is already bit 0
   assign inj_cur_n = (xfer & sr_first) ? inj_arm_q : inj_cur_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         inj_arm_q <= 1'b0;
         inj_cur_q <= 1'b0;
      end else if (xfer & sr_first) begin
         inj_cur_q <= inj_arm_q;
         inj_arm_q <= busy_o & inject_i;
      end else begin
         if (busy_o & inject_i)
            inj_arm_q <= 1'b1;
         if (reload)
            inj_cur_q <= 1'b0;
      end
   end
`else
   assign inj_cur_n = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         reps_q    <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         valid_o   <= 1'b0;
         data_o    <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               valid_o <= 1'b0;
               data_o  <= 1'b0;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
               if (start_i) begin
                  state_q   <= SEND;
                  valid_o   <= 1'b1;
                  busy_o    <= 1'b1;
                  data_o    <= frame_sel[PAT_W-1];
                  reps_q    <= (rep_i == '0) ? CNT_W'(1)
                                             : rep_i;
                  gap_q     <= gap_i;
                  gap_cnt_q <= '0;
               end
            end
            SEND: begin
               if (xfer) begin
                  if (!sr_last) begin
                     data_o <= sr_next ^ (sr_nlast & inj_cur_n);
                  end else begin
                     reps_q <= reps_q - 1'b1;
                     if (more) begin
                        if (gap_q != '0) begin
                           state_q   <= GAP;
                           valid_o   <= 1'b0;
                           data_o    <= 1'b0;
                           gap_cnt_q <= gap_q;
                        end else begin
                           // back-to-back: next MSB now
                           data_o <= sr_head;
                        end
                     end else begin
                        state_q <= DONE;
                        valid_o <= 1'b0;
                        data_o  <= 1'b0;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                     end
                  end
               end
            end
            GAP: begin
               gap_cnt_q <= gap_cnt_q - 1'b1;
               if (gap_cnt_q == GAP_W'(1)) begin
                  state_q <= SEND;
                  valid_o <= 1'b1;
                  data_o  <= sr_bit;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_o  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               valid_o <= 1'b0;
               data_o  <= 1'b0;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_moore_pattern_gen.sv
// Self-checking bench for moore_pattern_gen: directed vector table,
// hand-written corner sequences, random bursts vs. a token-stream model.
module tb_moore_pattern_gen;

   localparam int PAT_W = 5;
   localparam int CNT_W = 4;
   localparam int GAP_W = 4;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic             start_i = 1'b0;
   logic             use_def_i = 1'b0;
   logic [PAT_W-1:0] pattern_i = '0;
   logic [CNT_W-1:0] rep_i = '0;
   logic [GAP_W-1:0] gap_i = '0;
   logic             ready_i = 1'b0;
`ifdef PATGEN_ERR_INJECT_EN
   logic             inject_i = 1'b0;
`endif
   logic             valid_o;
   logic             data_o;
   logic             busy_o;
   logic             done_o;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk_i = ~clk_i;

   moore_pattern_gen dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .use_def_i (use_def_i),
      .pattern_i (pattern_i),
      .rep_i     (rep_i),
      .gap_i     (gap_i),
      .ready_i   (ready_i),
`ifdef PATGEN_ERR_INJECT_EN
      .inject_i  (inject_i),
`endif
      .valid_o   (valid_o),
      .data_o    (data_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   typedef struct {
      string            name;
      logic             start;
      logic             use_def;
      logic [PAT_W-1:0] pat;
      logic [CNT_W-1:0] rep;
      logic [GAP_W-1:0] gap;
      logic             ready;
      logic             inject;
      logic             ev;
      logic             ed;
      logic             eb;
      logic             edn;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(
      input string nm, input logic st, input logic ud,
      input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rep,
      input logic [GAP_W-1:0] gap, input logic rdy, input logic inj,
      input logic ev, input logic ed, input logic eb, input logic edn);
      vec_t v;
      v.name = nm; v.start = st; v.use_def = ud; v.pat = pat;
      v.rep = rep; v.gap = gap; v.ready = rdy; v.inject = inj;
      v.ev = ev; v.ed = ed; v.eb = eb; v.edn = edn;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic ev, input logic ed,
                      input logic eb, input logic edn);
      vec_cnt++;
      if ({valid_o, data_o, busy_o, done_o} !== {ev, ed, eb, edn}) begin
         err_cnt++;
         $display("FAIL %s t=%0t: got v=%b d=%b b=%b done=%b, want v=%b d=%b b=%b done=%b",
                  nm, $time, valid_o, data_o, busy_o, done_o,
                  ev, ed, eb, edn);
      end
   endtask

   // reference model: stream of tokens, one per output cycle
   // 0/1 = symbol waiting for ready, 2 = gap cycle, 3 = done pulse
   int mq[$];

   function automatic void build(input logic ud,
                                 input logic [PAT_W-1:0] pat,
                                 input int rep, input int gap);
      logic [PAT_W-1:0] f;
      int r;
      f = ud ? 5'b01101 : pat;
      r = (rep == 0) ? 1 : rep;
      for (int k = 0; k < r; k++) begin
         for (int b = PAT_W - 1; b >= 0; b--)
            mq.push_back(int'(f[b]));
         if (k < r - 1)
            for (int g = 0; g < gap; g++)
               mq.push_back(2);
      end
      mq.push_back(3);
   endfunction

   initial begin
      logic [PAT_W-1:0] bb_pat;
      int tok;

      // directed: single default frame
      add("def_b4", 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0);
      add("def_b3", 0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0);
      add("def_b2", 0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0);
      add("def_b1", 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0);
      add("def_b0", 0, 1, 0, 0, 0, 1, 0, 1, 1, 1, 0);
      add("def_done", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      add("def_idle", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      // repeat 2 with gap 3, frame 10011
      add("gap_f1b4", 1, 0, 5'b10011, 2, 3, 1, 0, 1, 1, 1, 0);
      add("gap_f1b3", 0, 0, 5'b10011, 2, 3, 1, 0, 1, 0, 1, 0);
      add("gap_f1b2", 0, 0, 5'b10011, 2, 3, 1, 0, 1, 0, 1, 0);
      add("gap_f1b1", 0, 0, 5'b10011, 2, 3, 1, 0, 1, 1, 1, 0);
      add("gap_f1b0", 0, 0, 5'b10011, 2, 3, 1, 0, 1, 1, 1, 0);
      add("gap_c1", 0, 0, 5'b10011, 2, 3, 1, 0, 0, 0, 1, 0);
      add("gap_c2", 0, 0, 5'b10011, 2, 3, 0, 0, 0, 0, 1, 0);
      add("gap_c3", 0, 0, 5'b10011, 2, 3, 1, 0, 0, 0, 1, 0);
      add("gap_f2b4", 0, 0, 5'b10011, 2, 3, 1, 0, 1, 1, 1, 0);
      add("gap_f2b3", 0, 0, 5'b10011, 2, 3, 1, 0, 1, 0, 1, 0);
      add("gap_f2b2", 0, 0, 5'b10011, 2, 3, 1, 0, 1, 0, 1, 0);
      add("gap_f2b1", 0, 0, 5'b10011, 2, 3, 1, 0, 1, 1, 1, 0);
      add("gap_f2b0", 0, 0, 5'b10011, 2, 3, 1, 0, 1, 1, 1, 0);
      add("gap_done", 0, 0, 5'b10011, 2, 3, 1, 0, 0, 0, 0, 1);
      add("gap_idle", 0, 0, 5'b10011, 2, 3, 1, 0, 0, 0, 0, 0);
      // backpressure, start pulsed mid-burst
      add("bp_b4", 1, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0);
      add("bp_b3", 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0);
      add("bp_h1", 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0);
      add("bp_h2", 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0);
      add("bp_b2", 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0);
      add("bp_h3", 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0);
      add("bp_b1", 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0);
      add("bp_b0", 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 0);
      add("bp_h4", 0, 1, 0, 1, 0, 0, 0, 1, 1, 1, 0);
      add("bp_done", 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1);
      add("bp_idle", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PATGEN_ERR_INJECT_EN
      // inject during frame 1 bit 3: frame 2 becomes 01100
      add("inj_f1b4", 1, 1, 0, 2, 0, 1, 0, 1, 0, 1, 0);
      add("inj_f1b3", 0, 1, 0, 2, 0, 1, 0, 1, 1, 1, 0);
      add("inj_f1b2", 0, 1, 0, 2, 0, 1, 1, 1, 1, 1, 0);
      add("inj_f1b1", 0, 1, 0, 2, 0, 1, 0, 1, 0, 1, 0);
      add("inj_f1b0", 0, 1, 0, 2, 0, 1, 0, 1, 1, 1, 0);
      add("inj_f2b4", 0, 1, 0, 2, 0, 1, 0, 1, 0, 1, 0);
      add("inj_f2b3", 0, 1, 0, 2, 0, 1, 0, 1, 1, 1, 0);
      add("inj_f2b2", 0, 1, 0, 2, 0, 1, 0, 1, 1, 1, 0);
      add("inj_f2b1", 0, 1, 0, 2, 0, 1, 0, 1, 0, 1, 0);
      add("inj_f2b0", 0, 1, 0, 2, 0, 1, 0, 1, 0, 1, 0);
      add("inj_done", 0, 1, 0, 2, 0, 1, 0, 0, 0, 0, 1);
      add("inj_idle", 0, 1, 0, 2, 0, 1, 0, 0, 0, 0, 0);
`endif

      // reset state
      repeat (2) @(negedge clk_i);
      chk("reset", 0, 0, 0, 0);
      rst_i = 1'b1;

      foreach (tbl[i]) begin
         start_i   = tbl[i].start;
         use_def_i = tbl[i].use_def;
         pattern_i = tbl[i].pat;
         rep_i     = tbl[i].rep;
         gap_i     = tbl[i].gap;
         ready_i   = tbl[i].ready;
`ifdef PATGEN_ERR_INJECT_EN
         inject_i  = tbl[i].inject;
`endif
         @(negedge clk_i);
         chk(tbl[i].name, tbl[i].ev, tbl[i].ed, tbl[i].eb, tbl[i].edn);
      end
      start_i = 1'b0;
`ifdef PATGEN_ERR_INJECT_EN
      inject_i = 1'b0;
`endif

      // back-to-back: 3 frames, no gap, 15 valid cycles
      bb_pat    = 5'b11010;
      start_i   = 1'b1;
      use_def_i = 1'b0;
      pattern_i = bb_pat;
      rep_i     = 3;
      gap_i     = 0;
      ready_i   = 1'b1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk_i);
         start_i = 1'b0;
         chk("b2b_bit", 1, bb_pat[PAT_W-1-(k%PAT_W)], 1, 0);
      end
      @(negedge clk_i);
      chk("b2b_done", 0, 0, 0, 1);
      @(negedge clk_i);
      chk("b2b_idle", 0, 0, 0, 0);

      // asynchronous reset in the middle of a frame
      start_i   = 1'b1;
      use_def_i = 1'b1;
      rep_i     = 3;
      ready_i   = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      chk("rst_b4", 1, 0, 1, 0);
      @(negedge clk_i);
      chk("rst_b3", 1, 1, 1, 0);
      #2 rst_i = 1'b0;
      #1 chk("rst_async", 0, 0, 0, 0);
      @(negedge clk_i);
      chk("rst_hold", 0, 0, 0, 0);
      rst_i = 1'b1;
      repeat (4) begin
         @(negedge clk_i);
         chk("rst_after", 0, 0, 0, 0);
      end

      // random bursts against the token model
      mq.delete();
      for (int c = 0; c < 4000; c++) begin
         if (mq.size() == 0) begin
            chk("rnd_idle", 0, 0, 0, 0);
         end else begin
            tok = mq[0];
            if (tok < 2)
               chk("rnd_bit", 1, tok[0], 1, 0);
            else if (tok == 2)
               chk("rnd_gap", 0, 0, 1, 0);
            else
               chk("rnd_done", 0, 0, 0, 1);
         end
         start_i   = ($urandom_range(0, 5) == 0);
         use_def_i = $urandom_range(0, 1);
         pattern_i = PAT_W'($urandom);
         rep_i     = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom)
                                                 : CNT_W'($urandom_range(0, 3));
         gap_i     = ($urandom_range(0, 7) == 0) ? GAP_W'($urandom)
                                                 : GAP_W'($urandom_range(0, 2));
         ready_i   = ($urandom_range(0, 3) != 0);
         if (mq.size() == 0) begin
            if (start_i)
               build(use_def_i, pattern_i, int'(rep_i), int'(gap_i));
         end else if (mq[0] >= 2 || ready_i) begin
            void'(mq.pop_front());
         end
         @(negedge clk_i);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vec_cnt, err_cnt);
      $finish;
   end

endmodule
